recv_game_difficulty: RTL and testbench



---
 rtl/recv_game_difficulty_if.sv | 23 ++
 rtl/recv_game_difficulty.sv | 96 +++++++++
 tb/tb_recv_game_difficulty.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/recv_game_difficulty_if.sv
// rtl/recv_game_difficulty_if.sv - byte/control/result bundle between UART RX, parser and game logic
interface recv_game_difficulty_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       block;
  logic [7:0] nivel_dificuldade;
  logic       dificuldade_valid;
  logic       frame_error;
  logic [1:0] error_code;
  logic       busy;

  // Host side: UART RX plus game control, drives bytes and block, observes results
  modport master (
    output rx_data, rx_valid, block,
    input  nivel_dificuldade, dificuldade_valid, frame_error, error_code, busy
  );

  // Parser side
  modport slave (
    input  rx_data, rx_valid, block,
    output nivel_dificuldade, dificuldade_valid, frame_error, error_code, busy
  );
endinterface

// File: rtl/recv_game_difficulty.sv
// rtl/recv_game_difficulty.sv - two-byte difficulty-select frame parser with range and timeout checks
module recv_game_difficulty #(
  parameter logic [7:0] EVENT_CODE     = 8'hAB,
  parameter logic [7:0] MIN_LEVEL      = 8'd1,
  parameter logic [7:0] MAX_LEVEL      = 8'd3,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input logic                   clk,
  input logic                   reset,
  recv_game_difficulty_if.slave bus
);

  typedef enum logic {IDLE, WAIT_LEVEL} state_t;

  localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_RANGE   = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

  state_t      state, state_nx;
  logic [15:0] timer, timer_nx;
  logic [7:0]  level, level_nx;
  logic        valid_q, valid_nx;
  logic        err_q, err_nx;
  logic [1:0]  code, code_nx;
  logic        in_range;

  assign in_range = (bus.rx_data >= MIN_LEVEL) && (bus.rx_data <= MAX_LEVEL);

  // Next state and next registered outputs; strobes default low so they last one cycle
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    level_nx = level;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    code_nx  = code;
    case (state)
      IDLE: begin
        if (bus.rx_valid && !bus.block && bus.rx_data == EVENT_CODE) begin
          state_nx = WAIT_LEVEL;
          timer_nx = '0;
        end
      end
      WAIT_LEVEL: begin
        if (bus.block) begin
          state_nx = IDLE;
        end else if (bus.rx_valid) begin
          // A received byte beats a coincident timeout; a repeated header is just out of range
          state_nx = IDLE;
          if (in_range) begin
            level_nx = bus.rx_data;
            valid_nx = 1'b1;
            code_nx  = ERR_NONE;
          end else begin
            err_nx  = 1'b1;
            code_nx = ERR_RANGE;
          end
        end else if (timer == TIMER_LIMIT) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
          code_nx  = ERR_TIMEOUT;
        end else begin
          timer_nx = timer + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, timer and output registers; reset discards any frame silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      timer   <= '0;
      level   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code    <= ERR_NONE;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      level   <= level_nx;
      valid_q <= valid_nx;
      err_q   <= err_nx;
      code    <= code_nx;
    end
  end

  assign bus.nivel_dificuldade = level;
  assign bus.dificuldade_valid = valid_q;
  assign bus.frame_error       = err_q;
  assign bus.error_code        = code;
  assign bus.busy              = (state == WAIT_LEVEL);

endmodule

// File: tb/tb_recv_game_difficulty.sv
// tb/tb_recv_game_difficulty.sv - scoreboard bench for the difficulty frame parser
module tb_recv_game_difficulty;
  localparam int         T    = 10;
  localparam logic [7:0] HDR  = 8'hAB;
  localparam logic [7:0] LMIN = 8'd1;
  localparam logic [7:0] LMAX = 8'd3;

  typedef struct {
    bit         is_err;
    logic [7:0] lvl;
    logic [1:0] code;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  recv_game_difficulty_if bus ();

  recv_game_difficulty #(
    .EVENT_CODE(HDR), .MIN_LEVEL(LMIN), .MAX_LEVEL(LMAX), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit in_rst = 1'b1;

  // Reference model: a frame is open from its header cycle; it closes on block, on any byte,
  // or when exactly T cycles have elapsed since the header with no byte.
  resp_t q[$];
  bit         m_open = 0;
  int         m_hdr_cyc = 0;
  int         cyc = 0;
  logic [7:0] m_level = 0;
  logic [1:0] m_code = 0;
  bit         pend = 0;
  resp_t      pend_r;
  bit         vis_busy = 0;
  logic [7:0] vis_level = 0;
  logic [1:0] vis_code = 0;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit v, logic [7:0] d, bit b);
    pend = 0;
    if (m_open) begin
      if (b) begin
        m_open = 0;
      end else if (v) begin
        m_open = 0;
        pend = 1;
        if (d >= LMIN && d <= LMAX) begin
          pend_r = '{is_err: 0, lvl: d, code: 2'b00};
          m_level = d;
          m_code = 2'b00;
        end else begin
          pend_r = '{is_err: 1, lvl: m_level, code: 2'b01};
          m_code = 2'b01;
        end
      end else if (cyc - m_hdr_cyc == T) begin
        m_open = 0;
        pend = 1;
        pend_r = '{is_err: 1, lvl: m_level, code: 2'b10};
        m_code = 2'b10;
      end
    end else if (v && !b && d == HDR) begin
      m_open = 1;
      m_hdr_cyc = cyc;
    end
  endtask

  // One clock of stimulus; results become visible after the edge
  task automatic cycle(bit v, logic [7:0] d, bit b);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.block    = b;
    model_step(v, d, b);
    @(posedge clk);
    #1;
    cyc++;
    if (pend) q.push_back(pend_r);
    vis_busy  = m_open;
    vis_level = m_level;
    vis_code  = m_code;
    bus.rx_valid = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0);
  endtask

  task automatic do_reset(int n);
    in_rst = 1;
    reset = 0;
    bus.rx_valid = 0;
    bus.rx_data = 0;
    bus.block = 0;
    m_open = 0; m_level = 0; m_code = 0; pend = 0;
    q.delete();
    vis_busy = 0; vis_level = 0; vis_code = 0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_level", bus.nivel_dificuldade, 8'h00);
    check("rst_valid", {7'd0, bus.dificuldade_valid}, 8'h00);
    check("rst_err", {7'd0, bus.frame_error}, 8'h00);
    check("rst_code", {6'd0, bus.error_code}, 8'h00);
    check("rst_busy", {7'd0, bus.busy}, 8'h00);
    reset = 1;
    in_rst = 0;
  endtask

  // Monitor: pops the scoreboard whenever a strobe appears and checks held outputs every cycle
  always @(negedge clk) begin
    if (reset && !in_rst) begin
      resp_t e;
      check("busy", {7'd0, bus.busy}, {7'd0, vis_busy});
      check("level_held", bus.nivel_dificuldade, vis_level);
      check("code_held", {6'd0, bus.error_code}, {6'd0, vis_code});
      check("both_strobes", {7'd0, bus.dificuldade_valid & bus.frame_error}, 8'h00);
      if (bus.dificuldade_valid || bus.frame_error) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {6'd0, bus.dificuldade_valid, bus.frame_error}, 8'h00);
        end else begin
          e = q.pop_front();
          check("strobe_kind", {6'd0, bus.dificuldade_valid, bus.frame_error},
                {6'd0, !e.is_err, e.is_err});
          check("strobe_level", bus.nivel_dificuldade, e.lvl);
          check("strobe_code", {6'd0, bus.error_code}, {6'd0, e.code});
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        check("missing_strobe", 8'h00, {6'd0, !e.is_err, e.is_err});
      end
    end
  end

  initial begin
    bus.rx_valid = 0;
    bus.rx_data = 0;
    bus.block = 0;
    do_reset(3);
    idle(2);
    // good frame, bad level, repeated header
    cycle(1, HDR, 0); cycle(1, 8'h02, 0); idle(2);
    cycle(1, HDR, 0); cycle(1, 8'h07, 0); idle(2);
    cycle(1, HDR, 0); cycle(1, HDR, 0); idle(2);
    // timeout, then byte exactly in the limit cycle
    cycle(1, HDR, 0); idle(T + 3);
    cycle(1, HDR, 0); idle(T - 1); cycle(1, 8'h03, 0); idle(2);
    // boundary levels 0 and 4, and 1
    cycle(1, HDR, 0); cycle(1, 8'h00, 0); idle(1);
    cycle(1, HDR, 0); cycle(1, 8'h04, 0); idle(1);
    cycle(1, HDR, 0); cycle(1, 8'h01, 0); idle(1);
    // stray bytes, blocked header, block mid-frame
    cycle(1, 8'h55, 0); cycle(1, 8'h00, 0); cycle(1, 8'hFF, 0); idle(1);
    cycle(1, HDR, 1); cycle(1, 8'h02, 0); idle(1);
    cycle(1, HDR, 0); cycle(0, 8'h00, 1); cycle(1, 8'h01, 0); idle(T + 2);
    // reset mid-frame
    cycle(1, HDR, 0);
    do_reset(1);
    cycle(1, 8'h01, 0); idle(T + 2);
    // back-to-back frames
    cycle(1, HDR, 0); cycle(1, 8'h01, 0); cycle(1, HDR, 0); cycle(1, 8'h03, 0); idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] d;
      bit v, b;
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 99) < 35);
      b = ($urandom_range(0, 99) < 4);
      if (r < 30) d = HDR;
      else if (r < 75) d = 8'($urandom_range(0, 4));
      else d = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end else begin
        cycle(v, d, b);
      end
    end
    idle(T + 3);
    check("queue_drained", 8'(q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
